tt_sweep: RTL

TT_SWEEP -- requirements
Module: tt_sweep

---
 rtl/tt_sweep.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tt_sweep.sv
// Truth-table sweeper: walks x through all 128 minterms of a 7-input function and captures f into tt.
// Optional TT_COMPARE_EN adds exp_tt/match for a registered compare against an expected table.
//   state  | meaning
//   IDLE   | waiting for start, x parked at 0, last tt/ones retained
//   DRIVE  | x held on the function inputs while it settles
//   SAMPLE | f captured into tt[x] and counted into ones
//   DONE   | tt/ones frozen and offered until tt_ready
module tt_sweep #(
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic [6:0]   x,
  input  logic         f,
  output logic [127:0] tt,
  output logic         tt_valid,
  input  logic         tt_ready,
  output logic [7:0]   ones
`ifdef TT_COMPARE_EN
  ,
  input  logic [127:0] exp_tt,
  output logic         match
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // DRIVE lasts SETTLE cycles, so the down-counter is loaded with SETTLE-1
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_e       state_q, state_d;
  logic [6:0]   x_q, x_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] tt_q, tt_d;
  logic [7:0]   ones_q, ones_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          x_d     = '0;
          cnt_d   = CNT_LOAD;
          tt_d    = '0;
          ones_d  = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        tt_d[x_q] = f;
        ones_d    = ones_q + {7'd0, f};
        // x saturates at 127 so DONE still shows the last minterm
        if (x_q == 7'd127) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
          x_d     = x_q + 7'd1;
          cnt_d   = CNT_LOAD;
        end
      end
      S_DONE: begin
        if (tt_ready) begin
          state_d = S_IDLE;
          x_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TT_COMPARE_EN
  logic match_q, match_d;

  always_comb begin
    match_d = match_q;
    if (state_q == S_IDLE && start)                    match_d = 1'b0;
    else if (state_q == S_SAMPLE && x_q == 7'd127)     match_d = (tt_d == exp_tt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) match_q <= 1'b0;
    else        match_q <= match_d;
  end

  assign match = match_q;
`endif

  assign busy     = (state_q != S_IDLE);
  assign tt_valid = (state_q == S_DONE);
  assign x        = x_q;
  assign tt       = tt_q;
  assign ones     = ones_q;

endmodule
